// File: rtl/chdr_pkt_rr_arbiter_if.sv
// CHDR fan-in bundle: per-port input streams plus the shared output stream.
// The arbiter takes the slave view; the upstream/downstream side takes master.
interface chdr_pkt_rr_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = 3
);
    logic [64*NUM_PORTS-1:0] i_tdata;
    logic [NUM_PORTS-1:0]    i_tlast;
    logic [NUM_PORTS-1:0]    i_tvalid;
    logic [NUM_PORTS-1:0]    i_tready;
    logic [63:0]             o_tdata;
    logic                    o_tlast;
    logic                    o_tvalid;
    logic                    o_tready;
    logic [PW-1:0]           o_port;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid,
        output i_tready,
        output o_tdata, o_tlast, o_tvalid, o_port,
        input  o_tready
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tlast, o_tvalid, o_port,
        output o_tready
    );
endinterface

// File: rtl/chdr_pkt_rr_arbiter.sv
// Packet-atomic round-robin arbiter: grants at packet boundaries, holds
// the grant until the tlast handshake, zero-latency mux while passing.
module chdr_pkt_rr_arbiter #(
    parameter int BASE      = 0,
    parameter int NUM_PORTS = 4,
    parameter int PW        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    chdr_pkt_rr_arbiter_if.slave  bus,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    output logic [31:0]           debug
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [PW-1:0]        last_q, last_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] mask_q;
    logic [NUM_PORTS-1:0] req;
    logic [PW-1:0]        pick;
    logic                 found;
    logic                 sel_valid;
    logic                 sel_last;
    logic [63:0]          sel_data;
    logic                 unused_set;

    assign unused_set = ^set_data[31:NUM_PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PW'(NUM_PORTS - 1);
            cnt_q   <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (set_stb && set_addr == 8'(BASE))
                mask_q <= set_data[NUM_PORTS-1:0];
        end
    end

    // Search order starts one past the last winner, so the search only
    // ever yields indices below NUM_PORTS.
    always_comb begin
        req   = bus.i_tvalid & mask_q;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && req[k] &&
                    ((int'(last_q) + i) % NUM_PORTS) == k) begin
                    found = 1'b1;
                    pick  = PW'(k);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_q == PW'(k)) begin
                sel_valid = bus.i_tvalid[k];
                sel_last  = bus.i_tlast[k];
                sel_data  = bus.i_tdata[64*k +: 64];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        bus.o_tvalid = 1'b0;
        bus.o_tlast  = 1'b0;
        bus.o_tdata  = '0;
        bus.i_tready = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = PASS;
                end
            end
            PASS: begin
                bus.o_tvalid = sel_valid;
                bus.o_tlast  = sel_last;
                bus.o_tdata  = sel_data;
                for (int k = 0; k < NUM_PORTS; k++)
                    if (grant_q == PW'(k))
                        bus.i_tready[k] = bus.o_tready;
                if (sel_valid && bus.o_tready && sel_last) begin
                    last_d  = grant_q;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_port = grant_q;
    assign debug = {state_q, 3'b000, 3'(grant_q), 8'(mask_q), cnt_q};
endmodule

// File: tb/tb_chdr_pkt_rr_arbiter.sv
// Directed bench: queue-driven sources, recorded output beats checked
// against hand-worked beat order and handshake cycles.
module tb_chdr_pkt_rr_arbiter;
    localparam int NP   = 4;
    localparam int PW   = 3;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [31:0] debug;

    always #5 clk = ~clk;

    chdr_pkt_rr_arbiter_if #(.NUM_PORTS(NP), .PW(PW)) bus ();

    chdr_pkt_rr_arbiter #(
        .BASE(BASE), .NUM_PORTS(NP), .PW(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .set_stb(set_stb),
        .set_addr(set_addr),
        .set_data(set_data),
        .debug(debug)
    );

    logic [64:0]   srcq [NP][$];
    logic [NP-1:0] stall;
    logic          rdy;
    logic [NP-1:0] rdy_seen;
    logic [63:0]   got_d [$];
    logic          got_l [$];
    logic [PW-1:0] got_p [$];
    int            got_c [$];
    int            cyc;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n;

    int e3p [12] = '{0, 0, 0, 0, 1, 1, 3, 3, 1, 1, 3, 3};
    int e3k [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int e3b [12] = '{0, 1, 2, 3, 0, 1, 0, 1, 0, 1, 0, 1};
    int e3c [12] = '{1, 2, 3, 4, 6, 7, 9, 10, 12, 13, 15, 16};
    int e4c [6]  = '{1, 2, 7, 9, 11, 12};

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(int p, int pk, int b);
        return {16'(p), 16'(pk), 32'(b)};
    endfunction

    task automatic push(int p, int pk, int nb);
        for (int b = 0; b < nb; b++)
            srcq[p].push_back({b == nb - 1, mk(p, pk, b)});
    endtask

    task automatic drive();
        logic [64:0] h;
        for (int k = 0; k < NP; k++) begin
            if (srcq[k].size() != 0 && !stall[k]) begin
                h = srcq[k][0];
                bus.i_tvalid[k]          = 1'b1;
                bus.i_tlast[k]           = h[64];
                bus.i_tdata[64*k +: 64]  = h[63:0];
            end else begin
                bus.i_tvalid[k]          = 1'b0;
                bus.i_tlast[k]           = 1'b0;
                bus.i_tdata[64*k +: 64]  = '0;
            end
        end
        bus.o_tready = rdy;
    endtask

    task automatic tick();
        logic [NP-1:0] pop;
        drive();
        #1;
        pop = bus.i_tvalid & bus.i_tready;
        rdy_seen = rdy_seen | bus.i_tready;
        if (bus.o_tvalid === 1'b1 && bus.o_tready) begin
            got_d.push_back(bus.o_tdata);
            got_l.push_back(bus.o_tlast);
            got_p.push_back(bus.o_port);
            got_c.push_back(cyc);
        end
        @(posedge clk);
        for (int k = 0; k < NP; k++)
            if (pop[k]) void'(srcq[k].pop_front());
        #1;
        cyc++;
    endtask

    task automatic ticks(int nt);
        for (int i = 0; i < nt; i++) tick();
    endtask

    task automatic clear();
        for (int k = 0; k < NP; k++) srcq[k].delete();
        got_d.delete();
        got_l.delete();
        got_p.delete();
        got_c.delete();
        stall    = '0;
        rdy      = 1'b1;
        rdy_seen = '0;
        cyc      = 0;
    endtask

    task automatic do_reset();
        clear();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_beat(string tag, int idx, int p, int pk, int b,
                            bit last, int c);
        if (idx < got_d.size()) begin
            check($sformatf("%s[%0d] data", tag, idx), got_d[idx], mk(p, pk, b));
            check($sformatf("%s[%0d] port", tag, idx), 64'(got_p[idx]), 64'(p));
            check($sformatf("%s[%0d] last", tag, idx), 64'(got_l[idx]), 64'(last));
            check($sformatf("%s[%0d] cyc", tag, idx), 64'(got_c[idx]), 64'(c));
        end else begin
            check($sformatf("%s[%0d] missing", tag, idx), 64'(got_d.size()),
                  64'(idx + 1));
        end
    endtask

    initial begin
        @(posedge clk);
        #1;

        // reset state and a write to a foreign address
        do_reset();
        check("rst debug", 64'(debug), 64'h000F_0000);
        check("rst tready", 64'(bus.i_tready), 64'h0);
        check("rst tvalid", 64'(bus.o_tvalid), 64'h0);
        check("rst port", 64'(bus.o_port), 64'h0);
        set_stb  = 1'b1;
        set_addr = 8'h01;
        set_data = 32'h0;
        tick();
        set_stb = 1'b0;
        tick();
        check("foreign addr mask", 64'(debug[23:16]), 64'h0F);

        // four 3-beat packets, all valid from reset
        do_reset();
        for (int p = 0; p < NP; p++) push(p, 0, 3);
        ticks(20);
        check("t1 beats", 64'(got_d.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            chk_beat("t1", i, i / 3, 0, i % 3, (i % 3) == 2,
                     4 * (i / 3) + 1 + (i % 3));
        check("t1 pkt_count", 64'(debug[15:0]), 64'd4);

        // port 0 arrives mid-packet on port 2
        do_reset();
        push(2, 0, 5);
        ticks(3);
        push(0, 0, 3);
        rdy_seen = '0;
        ticks(3);
        check("t2 rdy0 held", 64'(rdy_seen[0]), 64'h0);
        ticks(6);
        check("t2 beats", 64'(got_d.size()), 64'd8);
        for (int i = 0; i < 5; i++)
            chk_beat("t2", i, 2, 0, i, i == 4, i + 1);
        for (int i = 5; i < 8; i++)
            chk_beat("t2", i, 0, 0, i - 5, i == 7, i + 2);

        // mask write to 1010 while port 0 is mid-packet
        do_reset();
        push(0, 0, 4);
        push(0, 1, 2);
        for (int p = 1; p < NP; p++) begin
            push(p, 0, 2);
            push(p, 1, 2);
        end
        ticks(2);
        set_stb  = 1'b1;
        set_addr = 8'(BASE);
        set_data = 32'hFFFF_FFFA;
        tick();
        set_stb = 1'b0;
        ticks(19);
        check("t3 beats", 64'(got_d.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            chk_beat("t3", i, e3p[i], e3k[i], e3b[i],
                     (i >= 4) ? (e3b[i] == 1) : (i == 3), e3c[i]);
        check("t3 mask", 64'(debug[23:16]), 64'h0A);
        check("t3 port0 left", 64'(srcq[0].size()), 64'd2);
        check("t3 port2 left", 64'(srcq[2].size()), 64'd4);
        check("t3 rdy2 never", 64'(rdy_seen[2]), 64'h0);
        check("t3 pkt_count", 64'(debug[15:0]), 64'd5);

        // upstream stall plus o_tready toggling
        do_reset();
        push(1, 0, 6);
        ticks(3);
        for (int j = 0; j < 4; j++) begin
            stall[1] = 1'b1;
            rdy      = (j % 2) == 0;
            tick();
        end
        check("t4 grant held", 64'(debug[26:24]), 64'd1);
        check("t4 still pass", 64'(debug[31:30]), 64'd1);
        stall[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            rdy = (j % 2) == 0;
            tick();
        end
        rdy = 1'b1;
        ticks(5);
        check("t4 beats", 64'(got_d.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            chk_beat("t4", i, 1, 0, i, i == 5, e4c[i]);
        check("t4 pkt_count", 64'(debug[15:0]), 64'd1);

        // reset during beat 2 of a port 1 packet
        do_reset();
        push(1, 0, 1);
        push(1, 1, 4);
        ticks(3);
        push(0, 0, 2);
        ticks(2);
        check("t5 count pre", 64'(debug[15:0]), 64'd1);
        rst = 1'b1;
        tick();
        check("t5 state", 64'(debug[31:30]), 64'd0);
        check("t5 tready", 64'(bus.i_tready), 64'h0);
        check("t5 count", 64'(debug[15:0]), 64'd0);
        check("t5 grant", 64'(debug[26:24]), 64'd0);
        rst = 1'b0;
        n = got_d.size();
        ticks(2);
        chk_beat("t5", n, 0, 0, 0, 1'b0, 7);

        // single-beat packets on ports 1 and 3
        do_reset();
        push(1, 0, 1);
        push(3, 0, 1);
        ticks(6);
        check("t6 beats", 64'(got_d.size()), 64'd2);
        chk_beat("t6", 0, 1, 0, 0, 1'b1, 1);
        chk_beat("t6", 1, 3, 0, 0, 1'b1, 3);
        check("t6 pkt_count", 64'(debug[15:0]), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
